// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction-fetch stage. Owns the PC, a single-outstanding
//               instruction-memory request FSM and the IF/ID register with a
//               one-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_pc_sel,
  input  logic [31:0] ex_target,
  input  logic        stall_id,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_KILL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;

  logic        fire;
  logic        deliver;
  logic [31:0] target;
  logic        unused_tgt_bits;

  assign target          = {ex_target[31:2], 2'b00};
  assign unused_tgt_bits = ^ex_target[1:0];

  // rst_n gating keeps the request low while reset is held, since FETCH is the reset state
  assign im_req  = rst_n && (state_q == S_FETCH) && !buf_valid_q;
  assign fire    = im_req && im_ready;
  assign im_addr = pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    deliver  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (fire) begin
          req_pc_d = pc_q;
          if (ex_pc_sel) begin
            pc_d    = target;
            state_d = S_KILL;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = S_WAIT;
          end
        end else if (ex_pc_sel) begin
          pc_d = target;
        end
      end
      S_WAIT: begin
        if (ex_pc_sel) begin
          pc_d    = target;
          state_d = im_rvalid ? S_FETCH : S_KILL;
        end else if (im_rvalid) begin
          deliver = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_KILL: begin
        if (ex_pc_sel) pc_d = target;
        if (im_rvalid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    // The EX branch is older than the ID instruction, so flush wins over stall
    if (ex_pc_sel) begin
      id_valid_d  = 1'b0;
      id_inst_d   = NOP_INST;
      buf_valid_d = 1'b0;
    end else if (stall_id) begin
      if (deliver) begin
        buf_valid_d = 1'b1;
        buf_pc_d    = req_pc_q;
        buf_inst_d  = im_rdata;
      end
    end else if (buf_valid_q) begin
      id_valid_d  = 1'b1;
      id_pc_d     = buf_pc_q;
      id_inst_d   = buf_inst_q;
      buf_valid_d = 1'b0;
    end else if (deliver) begin
      id_valid_d = 1'b1;
      id_pc_d    = req_pc_q;
      id_inst_d  = im_rdata;
    end else begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'h0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'h0;
      buf_inst_q  <= 32'h0;
      id_valid_q  <= 1'b0;
      id_pc_q     <= 32'h0;
      id_inst_q   <= NOP_INST;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_inst_q   <= id_inst_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;

endmodule
`default_nettype wire
